// File: rtl/pc_stack_unit_if.sv
// Controller-to-fetch-datapath bundle: command strobes, ROM port and PC/IR/stack status.
// The controller (master) drives strobes; the ROM data rides in here so the block sees one bus.
// No handshake: every strobe is a single-cycle command executed on the next clk edge.
interface pc_stack_unit_if #(
    parameter int PC_W = 9,
    parameter int IR_W = 12
);
    logic            pc_inc;
    logic            pc_load;
    logic            pc_mux_sel;
    logic            ir_load;
    logic            stack_load;
    logic            stack_inc;
    logic            stack_dec;
    logic            pcl_we;
    logic [7:0]      pcl_din;
    logic [IR_W-1:0] prog_data;
    logic [PC_W-1:0] prog_addr;
    logic [IR_W-1:0] ir_bus;
    logic [PC_W-1:0] pc_q;
    logic [7:0]      pcl_q;
    logic [1:0]      stack_depth;
    logic            stk_ovf;
    logic            stk_unf;

    // Controller side (plus program ROM data source).
    modport master (
        output pc_inc, pc_load, pc_mux_sel, ir_load,
        output stack_load, stack_inc, stack_dec,
        output pcl_we, pcl_din, prog_data,
        input  prog_addr, ir_bus, pc_q, pcl_q, stack_depth, stk_ovf, stk_unf
    );

    // Fetch datapath side.
    modport slave (
        input  pc_inc, pc_load, pc_mux_sel, ir_load,
        input  stack_load, stack_inc, stack_dec,
        input  pcl_we, pcl_din, prog_data,
        output prog_addr, ir_bus, pc_q, pcl_q, stack_depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pc_stack_unit.sv
// PIC10F200 fetch datapath: program counter, instruction register and 2-level return stack.
// Latency: every strobe takes effect on the next clk edge; outputs are registered state.
// No backpressure: the controller owns sequencing, misuse is flagged via sticky stk_ovf/stk_unf.
module pc_stack_unit #(
    parameter int              PC_W         = 9,
    parameter int              IR_W         = 12,
    parameter int              STACK_DEPTH  = 2,
    parameter logic [PC_W-1:0] RESET_VECTOR = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst,
    pc_stack_unit_if.slave  bus
);

    localparam int DEPTH_W = 2;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [PC_W-1:0]    PC_ONE     = PC_W'(1);
    localparam logic [2:0]         OP_GOTO    = 3'b101;

    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_nxt;
    logic [IR_W-1:0]    ir_r;
    logic [PC_W-1:0]    stk_r [STACK_DEPTH];
    logic [PC_W-1:0]    pop_r;
    logic [DEPTH_W-1:0] depth_r;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               push_pending_r;
    logic               ovf_r;
    logic               unf_r;

    logic               stk_full;
    logic               stk_empty;
    logic               do_push;
    logic               do_pop;
    logic               do_inc;

    assign stk_full  = (depth_r == DEPTH_FULL);
    assign stk_empty = (depth_r == '0);

    // A push always wins over a pop in the same cycle; the second CALL cycle's
    // stack_inc is swallowed when the push one cycle earlier already counted.
    assign do_push = bus.stack_load;
    assign do_pop  = bus.stack_dec & ~bus.stack_load;
    assign do_inc  = bus.stack_inc & ~bus.stack_load & ~push_pending_r;

    // Next PC: pcl_we beats pc_load beats pc_inc; nothing asserted holds the PC.
    always_comb begin
        pc_nxt = pc_r;
        if (bus.pcl_we) begin
            // PCL writes always clear the page bit (bit 8).
            pc_nxt = {{(PC_W-8){1'b0}}, bus.pcl_din};
        end else if (bus.pc_load) begin
            if (bus.pc_mux_sel) begin
                if (ir_r[IR_W-1 -: 3] == OP_GOTO) begin
                    pc_nxt = ir_r[PC_W-1:0];
                end else begin
                    // CALL only carries an 8-bit target; upper bits forced low.
                    pc_nxt = {{(PC_W-8){1'b0}}, ir_r[7:0]};
                end
            end else begin
                pc_nxt = pop_r;
            end
        end else if (bus.pc_inc) begin
            pc_nxt = pc_r + PC_ONE;
        end
    end

    // Next depth: push and stray stack_inc count up (saturating), pop counts down (floored).
    always_comb begin
        depth_nxt = depth_r;
        if (do_push || do_inc) begin
            if (!stk_full) begin
                depth_nxt = depth_r + DEPTH_ONE;
            end
        end else if (do_pop) begin
            if (!stk_empty) begin
                depth_nxt = depth_r - DEPTH_ONE;
            end
        end
    end

    // PC and IR registers; IR samples the ROM word at the pre-update address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_VECTOR;
            ir_r <= '0;
        end else begin
            pc_r <= pc_nxt;
            if (bus.ir_load) begin
                ir_r <= bus.prog_data;
            end
        end
    end

    // Return stack data: shift down on push, shift up on pop with bottom entry duplicated.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STACK_DEPTH; k++) begin
                stk_r[k] <= '0;
            end
            pop_r <= '0;
        end else if (do_push) begin
            for (int k = STACK_DEPTH - 1; k > 0; k--) begin
                stk_r[k] <= stk_r[k-1];
            end
            stk_r[0] <= pc_r;
        end else if (do_pop) begin
            pop_r <= stk_r[0];
            for (int k = 0; k < STACK_DEPTH - 1; k++) begin
                stk_r[k] <= stk_r[k+1];
            end
        end
    end

    // Depth bookkeeping, CALL push tracking and sticky misuse flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_r        <= '0;
            push_pending_r <= 1'b0;
            ovf_r          <= 1'b0;
            unf_r          <= 1'b0;
        end else begin
            depth_r        <= depth_nxt;
            push_pending_r <= bus.stack_load;
            if (do_push && stk_full) begin
                ovf_r <= 1'b1;
            end
            if (do_pop && stk_empty) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign bus.prog_addr   = pc_r;
    assign bus.pc_q        = pc_r;
    assign bus.pcl_q       = pc_r[7:0];
    assign bus.ir_bus      = ir_r;
    assign bus.stack_depth = depth_r;
    assign bus.stk_ovf     = ovf_r;
    assign bus.stk_unf     = unf_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a cycle-by-cycle vector table plus short corner sequences.
// Each vector drives strobes at negedge and checks registered outputs 1 time unit after posedge.
// Expected values are hand-computed from the block's behaviour description.
module tb_pc_stack_unit;

    localparam int RST = 1;
    localparam int INC = 2;
    localparam int LD  = 4;
    localparam int MUX = 8;
    localparam int IRL = 16;
    localparam int SL  = 32;
    localparam int SI  = 64;
    localparam int SD  = 128;
    localparam int PW  = 256;

    typedef struct {
        logic        rst;
        logic        pc_inc;
        logic        pc_load;
        logic        pc_mux_sel;
        logic        ir_load;
        logic        stack_load;
        logic        stack_inc;
        logic        stack_dec;
        logic        pcl_we;
        logic [7:0]  pcl_din;
        logic [11:0] prog_data;
        logic [8:0]  epc;
        logic [11:0] eir;
        logic [1:0]  edepth;
        logic        eovf;
        logic        eunf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    pc_stack_unit_if #(.PC_W(9), .IR_W(12)) bus ();

    pc_stack_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int ctl, input logic [7:0] din, input logic [11:0] pd,
                                input logic [8:0] epc, input logic [11:0] eir,
                                input logic [1:0] ed, input logic eo, input logic eu);
        vec_t v;
        v.rst        = (ctl & RST) != 0;
        v.pc_inc     = (ctl & INC) != 0;
        v.pc_load    = (ctl & LD)  != 0;
        v.pc_mux_sel = (ctl & MUX) != 0;
        v.ir_load    = (ctl & IRL) != 0;
        v.stack_load = (ctl & SL)  != 0;
        v.stack_inc  = (ctl & SI)  != 0;
        v.stack_dec  = (ctl & SD)  != 0;
        v.pcl_we     = (ctl & PW)  != 0;
        v.pcl_din    = din;
        v.prog_data  = pd;
        v.epc        = epc;
        v.eir        = eir;
        v.edepth     = ed;
        v.eovf       = eo;
        v.eunf       = eu;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        logic [52:0] act;
        logic [52:0] exp;
        @(negedge clk);
        rst            = v.rst;
        bus.pc_inc     = v.pc_inc;
        bus.pc_load    = v.pc_load;
        bus.pc_mux_sel = v.pc_mux_sel;
        bus.ir_load    = v.ir_load;
        bus.stack_load = v.stack_load;
        bus.stack_inc  = v.stack_inc;
        bus.stack_dec  = v.stack_dec;
        bus.pcl_we     = v.pcl_we;
        bus.pcl_din    = v.pcl_din;
        bus.prog_data  = v.prog_data;
        @(posedge clk);
        #1;
        act = {bus.pc_q, bus.prog_addr, bus.pcl_q, bus.ir_bus, bus.stack_depth, bus.stk_ovf, bus.stk_unf};
        exp = {v.epc, v.epc, v.epc[7:0], v.eir, v.edepth, v.eovf, v.eunf};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc=%h addr=%h pcl=%h ir=%h depth=%0d ovf=%b unf=%b, want pc=%h ir=%h depth=%0d ovf=%b unf=%b",
                     nm, bus.pc_q, bus.prog_addr, bus.pcl_q, bus.ir_bus, bus.stack_depth, bus.stk_ovf, bus.stk_unf,
                     v.epc, v.eir, v.edepth, v.eovf, v.eunf);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.pc_inc = 1'b0;   bus.pc_load = 1'b0;    bus.pc_mux_sel = 1'b0;
        bus.ir_load = 1'b0;  bus.stack_load = 1'b0; bus.stack_inc = 1'b0;
        bus.stack_dec = 1'b0; bus.pcl_we = 1'b0;    bus.pcl_din = '0;
        bus.prog_data = '0;

        //                ctl                din    pd       pc      ir       d  o  u
        // reset and first fetch
        vecs.push_back(mk(RST,              8'h00, 12'hC25, 9'h1FF, 12'h000, 0, 0, 0));
        vecs.push_back(mk(IRL|INC,          8'h00, 12'hC25, 9'h000, 12'hC25, 0, 0, 0));
        // GOTO then CALL-style target
        vecs.push_back(mk(IRL,              8'h00, 12'hBAB, 9'h000, 12'hBAB, 0, 0, 0));
        vecs.push_back(mk(LD|MUX,           8'h00, 12'h000, 9'h1AB, 12'hBAB, 0, 0, 0));
        vecs.push_back(mk(IRL,              8'h00, 12'h9F0, 9'h1AB, 12'h9F0, 0, 0, 0));
        vecs.push_back(mk(LD|MUX,           8'h00, 12'h000, 9'h0F0, 12'h9F0, 0, 0, 0));
        // CALL / RETLW round trip from 010
        vecs.push_back(mk(PW,               8'h10, 12'h000, 9'h010, 12'h9F0, 0, 0, 0));
        vecs.push_back(mk(SL,               8'h00, 12'h000, 9'h010, 12'h9F0, 1, 0, 0));
        vecs.push_back(mk(SI|LD|MUX,        8'h00, 12'h000, 9'h0F0, 12'h9F0, 1, 0, 0));
        vecs.push_back(mk(INC,              8'h00, 12'h000, 9'h0F1, 12'h9F0, 1, 0, 0));
        vecs.push_back(mk(SD,               8'h00, 12'h000, 9'h0F1, 12'h9F0, 0, 0, 0));
        vecs.push_back(mk(LD,               8'h00, 12'h000, 9'h010, 12'h9F0, 0, 0, 0));
        // overflow with pushes of 005,006,007, then pops down to underflow
        vecs.push_back(mk(PW,               8'h05, 12'h000, 9'h005, 12'h9F0, 0, 0, 0));
        vecs.push_back(mk(SL|INC,           8'h00, 12'h000, 9'h006, 12'h9F0, 1, 0, 0));
        vecs.push_back(mk(SL|INC,           8'h00, 12'h000, 9'h007, 12'h9F0, 2, 0, 0));
        vecs.push_back(mk(SL,               8'h00, 12'h000, 9'h007, 12'h9F0, 2, 1, 0));
        vecs.push_back(mk(SD,               8'h00, 12'h000, 9'h007, 12'h9F0, 1, 1, 0));
        vecs.push_back(mk(LD,               8'h00, 12'h000, 9'h007, 12'h9F0, 1, 1, 0));
        vecs.push_back(mk(SD,               8'h00, 12'h000, 9'h007, 12'h9F0, 0, 1, 0));
        vecs.push_back(mk(LD,               8'h00, 12'h000, 9'h006, 12'h9F0, 0, 1, 0));
        vecs.push_back(mk(SD,               8'h00, 12'h000, 9'h006, 12'h9F0, 0, 1, 1));
        vecs.push_back(mk(PW,               8'h00, 12'h000, 9'h000, 12'h9F0, 0, 1, 1));
        vecs.push_back(mk(LD,               8'h00, 12'h000, 9'h006, 12'h9F0, 0, 1, 1));
        // PCL write clears bit 8 and beats other PC strobes
        vecs.push_back(mk(IRL,              8'h00, 12'hBF0, 9'h006, 12'hBF0, 0, 1, 1));
        vecs.push_back(mk(LD|MUX,           8'h00, 12'h000, 9'h1F0, 12'hBF0, 0, 1, 1));
        vecs.push_back(mk(PW|INC,           8'h3C, 12'h000, 9'h03C, 12'hBF0, 0, 1, 1));
        vecs.push_back(mk(PW|LD|MUX,        8'h80, 12'h000, 9'h080, 12'hBF0, 0, 1, 1));
        // wrap, load-over-inc, stray stack_inc saturating, reset clears flags
        vecs.push_back(mk(IRL,              8'h00, 12'hBFF, 9'h080, 12'hBFF, 0, 1, 1));
        vecs.push_back(mk(LD|MUX,           8'h00, 12'h000, 9'h1FF, 12'hBFF, 0, 1, 1));
        vecs.push_back(mk(INC,              8'h00, 12'h000, 9'h000, 12'hBFF, 0, 1, 1));
        vecs.push_back(mk(LD|MUX|INC,       8'h00, 12'h000, 9'h1FF, 12'hBFF, 0, 1, 1));
        vecs.push_back(mk(SI,               8'h00, 12'h000, 9'h1FF, 12'hBFF, 1, 1, 1));
        vecs.push_back(mk(SI,               8'h00, 12'h000, 9'h1FF, 12'hBFF, 2, 1, 1));
        vecs.push_back(mk(SI,               8'h00, 12'h000, 9'h1FF, 12'hBFF, 2, 1, 1));
        vecs.push_back(mk(RST|INC|SL|IRL,   8'h00, 12'h123, 9'h1FF, 12'h000, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous push and pop: only the push happens, pop register untouched.
        apply(mk(PW,     8'h22, 12'h000, 9'h022, 12'h000, 0, 0, 0), "pushpop_setpc");
        apply(mk(SL|SD,  8'h00, 12'h000, 9'h022, 12'h000, 1, 0, 0), "pushpop_same");
        apply(mk(LD,     8'h00, 12'h000, 9'h000, 12'h000, 1, 0, 0), "pushpop_popreg_kept");
        apply(mk(SD,     8'h00, 12'h000, 9'h000, 12'h000, 0, 0, 0), "pushpop_pop");
        apply(mk(LD,     8'h00, 12'h000, 9'h022, 12'h000, 0, 0, 0), "pushpop_ret");

        // Reset between the two CALL cycles discards the push and the pending flag.
        apply(mk(PW,        8'h40, 12'h000, 9'h040, 12'h000, 0, 0, 0), "midcall_setpc");
        apply(mk(SL,        8'h00, 12'h000, 9'h040, 12'h000, 1, 0, 0), "midcall_push");
        apply(mk(RST|SI|LD|MUX, 8'h00, 12'h000, 9'h1FF, 12'h000, 0, 0, 0), "midcall_rst");
        apply(mk(SI,        8'h00, 12'h000, 9'h1FF, 12'h000, 1, 0, 0), "midcall_inc_after_rst");
        apply(mk(SD,        8'h00, 12'h000, 9'h1FF, 12'h000, 0, 0, 0), "midcall_pop");
        apply(mk(LD,        8'h00, 12'h000, 9'h000, 12'h000, 0, 0, 0), "midcall_ret_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
